// File: rtl/vlsu_meta_buffer.sv
// Metadata FIFO between the VLSU control machine and the data controller.
// Optional macro VLSU_META_BUF_BYPASS_EN adds a same-cycle enq->deq path when the buffer is empty.
module vlsu_meta_buffer #(
    parameter int unsigned Depth        = 4,
    parameter type         meta_glb_t   = logic,
    parameter type         meta_seglv_t = logic
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         enq_valid_i,
    output logic                         enq_ready_o,
    input  meta_glb_t                    enq_glb_i,
    input  meta_seglv_t                  enq_seglv_i,
    output logic                         deq_valid_o,
    input  logic                         deq_ready_i,
    output meta_glb_t                    deq_glb_o,
    output meta_seglv_t                  deq_seglv_o,
    output logic [$clog2(Depth+1)-1:0]   count_o,
    output logic                         empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            full;
    logic            empty;
    logic            enq_fire;
    logic            mem_wr;
    logic            mem_rd;

    meta_glb_t   glb_mem   [Depth];
    meta_seglv_t seglv_mem [Depth];

    // Pointers wrap at Depth-1 so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full        = (count == CntW'(Depth));
    assign empty       = (count == '0);
    assign enq_ready_o = !full;
    assign enq_fire    = enq_valid_i && !full;
    assign count_o     = count;
    assign empty_o     = empty;

`ifdef VLSU_META_BUF_BYPASS_EN
    // An empty buffer forwards the incoming meta; it is only stored if not taken.
    assign deq_valid_o = !empty || enq_valid_i;
    assign deq_glb_o   = empty ? enq_glb_i   : glb_mem[rd_ptr];
    assign deq_seglv_o = empty ? enq_seglv_i : seglv_mem[rd_ptr];
    assign mem_wr      = enq_fire && !(empty && deq_ready_i);
    assign mem_rd      = deq_valid_o && deq_ready_i && !empty;
`else
    assign deq_valid_o = !empty;
    assign deq_glb_o   = glb_mem[rd_ptr];
    assign deq_seglv_o = seglv_mem[rd_ptr];
    assign mem_wr      = enq_fire;
    assign mem_rd      = deq_valid_o && deq_ready_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (mem_rd) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({mem_wr, mem_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; only pointers define validity.
    always_ff @(posedge clk_i) begin
        if (mem_wr && !flush_i) begin
            glb_mem[wr_ptr]   <= enq_glb_i;
            seglv_mem[wr_ptr] <= enq_seglv_i;
        end
    end

endmodule

// File: tb/tb_vlsu_meta_buffer.sv
// Randomised scoreboard bench for vlsu_meta_buffer; honours VLSU_META_BUF_BYPASS_EN when defined.
module tb_vlsu_meta_buffer;

    typedef logic [15:0] glb_t;
    typedef logic [7:0]  seg_t;
    typedef struct packed {
        glb_t glb;
        seg_t seg;
    } entry_t;

    localparam int Depth = 4;
`ifdef VLSU_META_BUF_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic       clk_i;
    logic       rst_i;
    logic       flush_i;
    logic       enq_valid_i;
    logic       enq_ready_o;
    glb_t       enq_glb_i;
    seg_t       enq_seglv_i;
    logic       deq_valid_o;
    logic       deq_ready_i;
    glb_t       deq_glb_o;
    seg_t       deq_seglv_o;
    logic [2:0] count_o;
    logic       empty_o;

    entry_t exp_q[$];
    int     occ;
    int     exp_count;
    int     vectors;
    int     miscompares;
    bit     mon_active;

    vlsu_meta_buffer #(
        .Depth       (Depth),
        .meta_glb_t  (glb_t),
        .meta_seglv_t(seg_t)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .enq_valid_i(enq_valid_i),
        .enq_ready_o(enq_ready_o),
        .enq_glb_i  (enq_glb_i),
        .enq_seglv_i(enq_seglv_i),
        .deq_valid_o(deq_valid_o),
        .deq_ready_i(deq_ready_i),
        .deq_glb_o  (deq_glb_o),
        .deq_seglv_o(deq_seglv_o),
        .count_o    (count_o),
        .empty_o    (empty_o)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs and updates the reference FIFO (a plain queue plus occupancy).
    task automatic applyStimulus(input bit enq, input bit deq, input bit flush);
        bit acc_enq;
        bit acc_deq;
        @(posedge clk_i);
        #1;
        flush_i     = flush;
        enq_valid_i = enq;
        deq_ready_i = flush ? 1'b0 : deq;
        enq_glb_i   = glb_t'($urandom);
        enq_seglv_i = seg_t'($urandom);
        exp_count   = occ;
        acc_enq = enq && !flush && (occ < Depth);
        acc_deq = deq_ready_i && ((occ > 0) || (Bypass && acc_enq));
        if (flush) begin
            exp_q.delete();
            occ = 0;
        end else begin
            if (acc_enq) exp_q.push_back('{glb: enq_glb_i, seg: enq_seglv_i});
            occ = occ + int'(acc_enq) - int'(acc_deq);
        end
    endtask

    // Monitor: mid-cycle, checks status against the model and retires the head on each handshake.
    initial begin
        entry_t head;
        forever begin
            @(posedge clk_i);
            #3;
            if (mon_active) begin
                checkOutput("count", 32'(count_o), 32'(exp_count));
                checkOutput("empty", 32'(empty_o), 32'(exp_count == 0));
                checkOutput("enq_ready", 32'(enq_ready_o), 32'(exp_count < Depth));
                checkOutput("deq_valid", 32'(deq_valid_o),
                            32'((exp_count > 0) || (Bypass && enq_valid_i && !rst_i)));
                if (deq_valid_o && deq_ready_i && !rst_i) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("deq_unexpected", 32'(1), 32'(0));
                    end else begin
                        head = exp_q.pop_front();
                        checkOutput("deq_glb", 32'(deq_glb_o), 32'(head.glb));
                        checkOutput("deq_seglv", 32'(deq_seglv_o), 32'(head.seg));
                    end
                end
            end
        end
    end

    // Main sequence: directed corner cases, random traffic, then an asynchronous mid-run reset.
    initial begin
        vectors     = 0;
        miscompares = 0;
        occ         = 0;
        exp_count   = 0;
        mon_active  = 1'b0;
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        enq_valid_i = 1'b0;
        deq_ready_i = 1'b0;
        enq_glb_i   = '0;
        enq_seglv_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i      = 1'b0;
        mon_active = 1'b1;

        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);

        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        repeat (600) applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                                   $urandom_range(0, 99) < 3);

        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        enq_valid_i = 1'b0;
        deq_ready_i = 1'b0;
        exp_q.delete();
        occ       = 0;
        exp_count = 0;
        #1;
        checkOutput("async_rst_count", 32'(count_o), 32'(0));
        checkOutput("async_rst_deq_valid", 32'(deq_valid_o), 32'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        repeat (100) applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(posedge clk_i);
        #4;
        mon_active = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
